// File: rtl/sw_array_controller.sv
// Sequencer for the Smith-Waterman systolic array: loads NUM_PES query symbols,
//   inserts NUM_PES-1 bubble cycles, then streams the target with init and drains.
// Latency: result_valid pulses 2*NUM_PES + target_len + ARRAY_LAT cycles after start.
// Backpressure: none is absorbed; a missing q_valid/t_valid in its window aborts the job with err.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   start, target_len     job request (sampled only in IDLE)
//   q_valid/q_data/q_ready  query symbol stream
//   t_valid/t_data/t_ready  target symbol stream
//   S_out, store_S_out    query load into the array
//   T_out, init_out       target stream into the array
//   V_in                  final-PE score from the array (signed)
//   busy, result_valid    job status
//   max_score, max_pos    best score and its 0-based target index
//   err                   stream underflow seen in the last job
module sw_array_controller #(
  parameter int NUM_PES   = 10,
  parameter int WIDTH     = 10,
  parameter int TLEN_W    = 16,
  parameter int ARRAY_LAT = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TLEN_W-1:0] target_len,
  input  logic              q_valid,
  input  logic [1:0]        q_data,
  output logic              q_ready,
  input  logic              t_valid,
  input  logic [1:0]        t_data,
  output logic              t_ready,
  output logic [1:0]        S_out,
  output logic              store_S_out,
  output logic [1:0]        T_out,
  output logic              init_out,
  input  logic [WIDTH-1:0]  V_in,
  output logic              busy,
  output logic              result_valid,
  output logic [WIDTH-1:0]  max_score,
  output logic [TLEN_W-1:0] max_pos,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BUBBLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  // Terminal counts for the fixed-length phases.
  localparam logic [TLEN_W-1:0] LOAD_LAST   = TLEN_W'(NUM_PES - 1);
  localparam logic [TLEN_W-1:0] BUBBLE_LAST = TLEN_W'(NUM_PES - 2);
  localparam logic [TLEN_W-1:0] DRAIN_LAST  = TLEN_W'(ARRAY_LAT - 1);

  state_t              state_q, state_d;
  logic [TLEN_W-1:0]   cnt_q, cnt_d;
  logic [TLEN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]    max_score_q, max_score_d;
  logic [TLEN_W-1:0]   max_pos_q, max_pos_d;
  logic                err_q, err_d;

  // Registered status/handshake outputs, decoded from the next state so they
  // line up exactly with the state they describe.
  logic                q_ready_q, q_ready_d;
  logic                t_ready_q, t_ready_d;
  logic                init_q, init_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;

  // Delay line pairing each streamed target index with the score that comes
  // back ARRAY_LAT cycles later on V_in.
  logic [ARRAY_LAT-1:0] dl_vld_q, dl_vld_d;
  logic [TLEN_W-1:0]    dl_idx_q [ARRAY_LAT];
  logic                 push;
  logic                 capture;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    max_score_d = max_score_q;
    max_pos_d   = max_pos_q;
    err_d       = err_q;
    push        = 1'b0;
    dl_vld_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = target_len;
          cnt_d       = '0;
          max_score_d = '0;
          max_pos_d   = '0;
          err_d       = 1'b0;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!q_valid) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_BUBBLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BUBBLE: begin
        if (cnt_q == BUBBLE_LAST) begin
          cnt_d   = '0;
          state_d = (len_q != '0) ? S_STREAM : S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STREAM: begin
        if (!t_valid) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          push = 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Scores are only meaningful while the job is streaming or draining; an
    // aborted job leaves stale entries in the delay line that must not leak
    // into the held result.
    capture = (state_q == S_STREAM || state_q == S_DRAIN) &&
              dl_vld_q[ARRAY_LAT-1] &&
              ($signed(V_in) > $signed(max_score_q));
    if (capture) begin
      max_score_d = V_in;
      max_pos_d   = dl_idx_q[ARRAY_LAT-1];
    end

    // Shift the valid bits; a new job starts with an empty line.
    if (!(state_q == S_IDLE && start)) begin
      for (int i = ARRAY_LAT - 1; i > 0; i--) begin
        dl_vld_d[i] = dl_vld_q[i-1];
      end
      dl_vld_d[0] = push;
    end

    q_ready_d      = (state_d == S_LOAD);
    t_ready_d      = (state_d == S_STREAM);
    init_d         = (state_d == S_STREAM) && (state_q != S_STREAM);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      len_q          <= '0;
      max_score_q    <= '0;
      max_pos_q      <= '0;
      err_q          <= 1'b0;
      dl_vld_q       <= '0;
      q_ready_q      <= 1'b0;
      t_ready_q      <= 1'b0;
      init_q         <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      max_score_q    <= max_score_d;
      max_pos_q      <= max_pos_d;
      err_q          <= err_d;
      dl_vld_q       <= dl_vld_d;
      q_ready_q      <= q_ready_d;
      t_ready_q      <= t_ready_d;
      init_q         <= init_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Index payload needs no reset: it is qualified by dl_vld_q.
  always_ff @(posedge clk) begin
    dl_idx_q[0] <= cnt_q;
    for (int i = 1; i < ARRAY_LAT; i++) begin
      dl_idx_q[i] <= dl_idx_q[i-1];
    end
  end

  // Symbol paths are gated by the registered enables so the array sees the
  // symbol in the same cycle it is accepted, and zero everywhere else.
  assign q_ready      = q_ready_q;
  assign t_ready      = t_ready_q;
  assign store_S_out  = q_ready_q & q_valid;
  assign S_out        = q_ready_q ? q_data : 2'b00;
  assign T_out        = t_ready_q ? t_data : 2'b00;
  assign init_out     = init_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign max_score    = max_score_q;
  assign max_pos      = max_pos_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sw_array_controller.sv
// Testbench for sw_array_controller: randomized jobs checked cycle by cycle
//   against a timeline/score model derived from the job parameters.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_sw_array_controller;

  localparam int N  = 10;
  localparam int W  = 10;
  localparam int TW = 16;
  localparam int A  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] target_len;
  logic          q_valid;
  logic [1:0]    q_data;
  logic          q_ready;
  logic          t_valid;
  logic [1:0]    t_data;
  logic          t_ready;
  logic [1:0]    S_out;
  logic          store_S_out;
  logic [1:0]    T_out;
  logic          init_out;
  logic [W-1:0]  V_in;
  logic          busy;
  logic          result_valid;
  logic [W-1:0]  max_score;
  logic [TW-1:0] max_pos;
  logic          err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] score [64];

  always #5 clk = ~clk;

  sw_array_controller #(
    .NUM_PES  (N),
    .WIDTH    (W),
    .TLEN_W   (TW),
    .ARRAY_LAT(A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target_len  (target_len),
    .q_valid     (q_valid),
    .q_data      (q_data),
    .q_ready     (q_ready),
    .t_valid     (t_valid),
    .t_data      (t_data),
    .t_ready     (t_ready),
    .S_out       (S_out),
    .store_S_out (store_S_out),
    .T_out       (T_out),
    .init_out    (init_out),
    .V_in        (V_in),
    .busy        (busy),
    .result_valid(result_valid),
    .max_score   (max_score),
    .max_pos     (max_pos),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, " q_ready"},      {31'b0, q_ready},      0);
    chk({pfx, " t_ready"},      {31'b0, t_ready},      0);
    chk({pfx, " store_S_out"},  {31'b0, store_S_out},  0);
    chk({pfx, " S_out"},        {30'b0, S_out},        0);
    chk({pfx, " T_out"},        {30'b0, T_out},        0);
    chk({pfx, " init_out"},     {31'b0, init_out},     0);
    chk({pfx, " busy"},         {31'b0, busy},         0);
    chk({pfx, " result_valid"}, {31'b0, result_valid}, 0);
    chk({pfx, " max_score"},    {22'b0, max_score},    0);
    chk({pfx, " max_pos"},      {16'b0, max_pos},      0);
    chk({pfx, " err"},          {31'b0, err},          0);
  endtask

  // Runs one job. Caller is just after a posedge. qdrop: LOAD cycle (1..N)
  // where q_valid drops, 0 for none. tdrop: STREAM offset where t_valid
  // drops, -1 for none. Scores for target index i are taken from score[i].
  task automatic run_job(input int jid, input int L, input int qdrop, input int tdrop);
    int   load_last, done_k, s_first, s_last, exp_max, exp_pos, idx;
    logic exp_err, qr, tr;
    string p;

    // Expected timeline, counted from the edge that samples start (edge 0).
    s_first = 1;
    s_last  = 0;
    if (qdrop > 0) begin
      load_last = qdrop;
      done_k    = qdrop + 1;
      exp_err   = 1'b1;
    end else begin
      load_last = N;
      if (L == 0) begin
        done_k  = 2 * N;
        exp_err = 1'b0;
      end else if (tdrop >= 0) begin
        s_first = 2 * N;
        s_last  = 2 * N + tdrop;
        done_k  = s_last + 1;
        exp_err = 1'b1;
      end else begin
        s_first = 2 * N;
        s_last  = 2 * N + L - 1;
        done_k  = s_last + A + 1;
        exp_err = 1'b0;
      end
    end

    // Expected result: strict running max from 0 over the scores that return
    // before the job leaves STREAM/DRAIN.
    exp_max = 0;
    exp_pos = 0;
    for (int i = 0; i < L; i++) begin
      if (qdrop == 0 && (2 * N + A + i) <= done_k - 1 && $signed(score[i]) > exp_max) begin
        exp_max = $signed(score[i]);
        exp_pos = i;
      end
    end

    #1;
    start      = 1'b1;
    target_len = TW'(L);
    q_valid    = 1'b0;
    t_valid    = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= done_k + 1; k++) begin
      #1;
      start      = (k <= done_k) ? ($urandom_range(0, 5) == 0) : 1'b0;
      target_len = TW'($urandom);
      q_data     = 2'($urandom);
      t_data     = 2'($urandom);
      q_valid    = (k <= load_last) ? (k != qdrop) : 1'($urandom);
      t_valid    = (k >= s_first && k <= s_last) ? (k != s_last || tdrop < 0) : 1'($urandom);
      idx        = k - (2 * N + A);
      V_in       = (idx >= 0 && idx < L) ? score[idx] : W'($urandom);
      @(negedge clk);
      qr = (k <= load_last);
      tr = (k >= s_first && k <= s_last);
      p  = $sformatf("job%0d cyc%0d", jid, k);
      chk({p, " q_ready"},      {31'b0, q_ready},      {31'b0, qr});
      chk({p, " store_S_out"},  {31'b0, store_S_out},  {31'b0, qr & q_valid});
      chk({p, " S_out"},        {30'b0, S_out},        {30'b0, (qr ? q_data : 2'b00)});
      chk({p, " t_ready"},      {31'b0, t_ready},      {31'b0, tr});
      chk({p, " T_out"},        {30'b0, T_out},        {30'b0, (tr ? t_data : 2'b00)});
      chk({p, " init_out"},     {31'b0, init_out},     {31'b0, (k == s_first && s_first <= s_last)});
      chk({p, " busy"},         {31'b0, busy},         {31'b0, (k <= done_k)});
      chk({p, " result_valid"}, {31'b0, result_valid}, {31'b0, (k == done_k)});
      if (k >= done_k) begin
        chk({p, " max_score"}, {22'b0, max_score}, {22'b0, W'(exp_max)});
        chk({p, " max_pos"},   {16'b0, max_pos},   exp_pos);
        chk({p, " err"},       {31'b0, err},       {31'b0, exp_err});
      end
      @(posedge clk);
    end
  endtask

  // Reset asserted during STREAM of a 30-symbol job; caller is just after a posedge.
  task automatic reset_mid_job();
    #1;
    start      = 1'b1;
    target_len = 30;
    q_valid    = 1'b1;
    t_valid    = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      #1;
      start   = 1'b0;
      q_data  = 2'($urandom);
      t_data  = 2'($urandom);
      V_in    = W'($urandom);
      rst     = (k == 25) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 24) chk("rstjob pre t_ready", {31'b0, t_ready}, 1);
      if (k == 26) chk_all_zero("rstjob post");
      if (k >= 26) begin
        chk($sformatf("rstjob cyc%0d result_valid", k), {31'b0, result_valid}, 0);
        chk($sformatf("rstjob cyc%0d busy", k),         {31'b0, busy},         0);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    int L, qd, td;
    rst        = 1'b0;
    start      = 1'b0;
    target_len = '0;
    q_valid    = 1'b0;
    q_data     = '0;
    t_valid    = 1'b0;
    t_data     = '0;
    V_in       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);

    // Default gapless job, random scores.
    for (int i = 0; i < 64; i++) score[i] = W'($urandom);
    run_job(0, 20, 0, -1);

    // Tie handling: 3, 7, 7, -2, 5 -> 7 at index 1.
    score[0] = W'(3);
    score[1] = W'(7);
    score[2] = W'(7);
    score[3] = W'(-2);
    score[4] = W'(5);
    run_job(1, 5, 0, -1);

    // All negative scores never beat the initial 0.
    for (int i = 0; i < 8; i++) score[i] = W'(-1 - int'($urandom_range(0, 500)));
    run_job(2, 8, 0, -1);

    // Empty target.
    run_job(3, 0, 0, -1);

    // Query underflow at LOAD cycle 4.
    for (int i = 0; i < 64; i++) score[i] = W'($urandom_range(1, 511));
    run_job(4, 20, 4, -1);

    // Target underflow mid-stream, late and early.
    run_job(5, 20, 0, 15);
    run_job(6, 20, 0, 3);

    // Leave a nonzero result behind, then reset in the middle of a job.
    score[2] = W'(300);
    run_job(7, 6, 0, -1);
    reset_mid_job();

    // Fresh job after reset.
    for (int i = 0; i < 64; i++) score[i] = W'($urandom);
    run_job(8, 20, 0, -1);

    // Random jobs.
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < 64; i++) score[i] = W'($urandom);
      L  = $urandom_range(0, 40);
      qd = ($urandom_range(0, 4) == 0) ? $urandom_range(1, N) : 0;
      td = (L > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : -1;
      run_job(10 + j, L, qd, td);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_array_controller.md
Name: sw_array_controller

Overview:
- Sequencer for the fixed Smith-Waterman systolic array with sequential query loading.
- Accepts a job (start + target length), shifts NUM_PES query symbols into the array and inserts the mandatory NUM_PES-1 bubble cycles.
- Then streams target symbols with init, drains the pipeline and reports the maximum alignment score and its target position.
- Sits between the host-side symbol streams and the array's S/T/store_S/init/V ports.

Parameters:
- NUM_PES, 10, PEs in the controlled array; number of query symbols per job.
- WIDTH, 10, score width; V_in is treated as signed two's complement.
- TLEN_W, 16, width of the target length and position counters.
- ARRAY_LAT, 10, cycles from a T symbol leaving T_out to its final-PE score on V_in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- target_len  in  TLEN_W  target length; sampled with start.
- q_valid  in  1  query symbol valid.
- q_data  in  2  query symbol.
- q_ready  out  1  controller accepting a query symbol.
- t_valid  in  1  target symbol valid.
- t_data  in  2  target symbol.
- t_ready  out  1  controller accepting a target symbol.
- S_out  out  2  to array S_in.
- store_S_out  out  1  to array store_S_in.
- T_out  out  2  to array T_in.
- init_out  out  1  to array init_in.
- V_in  in  WIDTH  from array V_out.
- busy  out  1  job in progress (not IDLE).
- result_valid  out  1  one-cycle pulse when results are final.
- max_score  out  WIDTH  maximum signed score of the last job; held until the next start.
- max_pos  out  TLEN_W  0-based target index that produced max_score.
- err  out  1  stream underflow in the last job; held until the next start.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; all outputs 0, including max_score, max_pos and err.
- Reset mid-job aborts immediately; no result_valid is issued.
- State IDLE: start=1 latches target_len, clears max_score/max_pos/err/counters, next state is LOAD.
- start is ignored while busy.
- State LOAD, NUM_PES cycles:
  - q_ready=1, store_S_out=q_valid, S_out=q_data.
  - The first accepted symbol ends in the last PE.
  - If q_valid=0 on any LOAD cycle: set err, go to DONE.
- State BUBBLE, NUM_PES-1 cycles: store_S_out=0, T_out=0, init_out=0, both readies 0.
  - Then go to STREAM if the latched length ≠ 0, else to DONE (max_score=0, max_pos=0).
- State STREAM, target_len cycles:
  - t_ready=1, T_out=t_data.
  - init_out=1 on the first STREAM cycle only.
  - If t_valid=0 on any STREAM cycle: set err, go to DONE.
- State DRAIN, ARRAY_LAT cycles: T_out=0, init_out=0.
- State DONE, 1 cycle: result_valid=1, then IDLE.
  - On an err abort, max_score/max_pos hold whatever was captured so far.
- Score capture:
  - Each STREAM cycle pushes {valid=1, index} into an ARRAY_LAT-deep delay line.
  - When the delay-line output is valid and signed V_in > max_score (strict), update max_score=V_in and max_pos=index.
  - Ties keep the earliest index; the initial max is 0, so negative scores are never captured.
- Timing: with start seen at edge 0, LOAD occupies cycles 1..N, BUBBLE N+1..2N-1, STREAM 2N..2N+L-1, DRAIN next ARRAY_LAT cycles. result_valid falls at cycle 2N+L+ARRAY_LAT.
- All array-facing outputs are registered, 0 outside their active states; busy=0 only in IDLE.

Test Plan:
- Defaults, start with target_len=20, gapless streams -> q_ready high cycles 1-10; store_S_out high exactly 10 cycles; 9 bubble cycles; init_out high only at cycle 20; t_ready cycles 20-39; result_valid single pulse at cycle 50; busy low from cycle 51.
- Force V_in during capture window to sequence 3, 7, 7, -2, 5 (first valid at cycle 30) -> max_score=7, max_pos=1 (earliest tie).
- All captured V_in negative -> max_score=0, max_pos=0, err=0.
- target_len=0 -> t_ready never asserted, no init_out, result_valid at cycle 20, max_score=0.
- Drop q_valid at LOAD cycle 4 -> err=1, result_valid next cycle; drop t_valid mid-STREAM -> err=1, no further t_ready.
- Assert rst=0 during STREAM, then release -> all outputs 0, IDLE; start during busy ignored; a fresh job after reset completes normally.
